// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: two one-entry writeback buffers (A=ALU, B=load) sharing one registered register-file write port.
module wb_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic [31:0] pend
);
  logic        a_v, b_v, last, a_old;
  logic [4:0]  a_a, b_a;
  logic [31:0] a_d, b_d;
  logic        g_a, g_b, a_acc, b_acc, a_keep, b_keep;
  assign a_ready = rdy & ~a_v;
  assign b_ready = rdy & ~b_v;
  assign a_acc   = a_valid & a_ready & |a_addr;
  assign b_acc   = b_valid & b_ready & |b_addr;
  assign a_keep  = a_v & ~g_a;
  assign b_keep  = b_v & ~g_b;
  // last=1 means B was granted last, so A wins the next distinct-address tie
  always_comb begin
    g_a = a_v & (~b_v | (a_a == b_a ? a_old : last));
    g_b = b_v & ~g_a;
    pend = '0;
    if (a_v) pend[a_a] = 1'b1;
    if (b_v) pend[b_a] = 1'b1;
    pend[0] = 1'b0;
  end
  // a_old: A survives while B newly fills, or both survive and A was already older
  always_ff @(posedge clk)
    if (rst) begin
      a_v   <= 1'b0;
      b_v   <= 1'b0;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      last  <= 1'b1;
      a_old <= 1'b0;
    end else if (rdy) begin
      a_v   <= a_keep | a_acc;
      b_v   <= b_keep | b_acc;
      a_old <= (a_keep & b_acc) | (a_old & a_keep & b_keep);
      we    <= g_a | g_b;
      if (a_acc) begin
        a_a <= a_addr;
        a_d <= a_data;
      end
      if (b_acc) begin
        b_a <= b_addr;
        b_d <= b_data;
      end
      if (g_a | g_b) begin
        waddr <= g_a ? a_a : b_a;
        wdata <= g_a ? a_d : b_d;
        last  <= g_b;
      end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed + random stimulus, sequence-numbered reference model, write scoreboard.
module tb_wb_port_arbiter;
  logic        clk = 0, rst = 1, rdy = 0, a_valid = 0, b_valid = 0;
  logic [4:0]  a_addr = 0, b_addr = 0;
  logic [31:0] a_data = 0, b_data = 0;
  logic        a_ready, b_ready, we;
  logic [4:0]  waddr;
  logic [31:0] wdata, pend;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .pend(pend)
  );

  // Reference model: each buffered entry carries a global arrival number; lower number = older.
  bit          mav = 0, mbv = 0, mlast = 1, m_we = 0, fresh = 0, inited = 0;
  bit          ar, br, ga, gb;
  logic [4:0]  ma = 0, mb = 0, m_waddr = 0;
  logic [31:0] mad = 0, mbd = 0, m_wdata = 0, exp_p;
  int unsigned mas = 0, mbs = 0, seq = 0;
  logic [36:0] q[$];
  logic [36:0] e;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mav = 0; mbv = 0; m_we = 0; m_waddr = 0; m_wdata = 0; mlast = 1; fresh = 0; inited = 1;
      q.delete();
    end else if (rdy) begin
      fresh = 1;
      ar = !mav;
      br = !mbv;
      ga = mav && (!mbv || (ma == mb ? (mas < mbs) : mlast));
      gb = mbv && !ga;
      m_we = ga || gb;
      if (m_we) begin
        m_waddr = ga ? ma : mb;
        m_wdata = ga ? mad : mbd;
        mlast = gb;
        q.push_back({m_waddr, m_wdata});
      end
      if (ga) mav = 0;
      if (gb) mbv = 0;
      if (b_valid && br && b_addr != 0) begin mbv = 1; mb = b_addr; mbd = b_data; mbs = seq++; end
      if (a_valid && ar && a_addr != 0) begin mav = 1; ma = a_addr; mad = a_data; mas = seq++; end
    end else fresh = 0;
  end

  initial forever begin
    @(negedge clk);
    if (inited) begin
      exp_p = 0;
      if (mav) exp_p[ma] = 1'b1;
      if (mbv) exp_p[mb] = 1'b1;
      exp_p[0] = 1'b0;
      chk("a_ready", 32'(a_ready), 32'(rdy & !mav));
      chk("b_ready", 32'(b_ready), 32'(rdy & !mbv));
      chk("pend", pend, exp_p);
      chk("we", 32'(we), 32'(m_we));
      chk("waddr", 32'(waddr), 32'(m_waddr));
      chk("wdata", wdata, m_wdata);
      if (we && fresh) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_unexpected: got write x%0d=%h expected none", waddr, wdata);
        end else begin
          e = q.pop_front();
          chk("sb_waddr", 32'(waddr), 32'(e[36:32]));
          chk("sb_wdata", wdata, e[31:0]);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic s, input logic av, input logic [4:0] aa,
                       input logic [31:0] ad, input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    rst = r; rdy = s; a_valid = av; a_addr = aa; a_data = ad; b_valid = bv; b_addr = ba; b_data = bd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [4:0] raddr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    drive(0, 1, 1, 5, 32'h11, 0, 0, 0);
    idle(4);
    drive(0, 1, 1, 3, 32'hA, 1, 4, 32'hB);
    idle(4);
    drive(0, 1, 1, 7, 32'h1, 1, 7, 32'h2);
    idle(4);
    drive(0, 1, 0, 0, 0, 1, 0, 32'hFFFF_FFFF);
    idle(3);
    drive(0, 1, 1, 9, 32'h90, 1, 10, 32'hA0);
    repeat (3) drive(0, 0, 1, 11, 32'hB0, 1, 12, 32'hC0);
    idle(5);
    drive(0, 1, 1, 13, 32'hD0, 1, 14, 32'hE0);
    drive(0, 1, 1, 15, 32'hF0, 1, 16, 32'h100);
    drive(0, 1, 1, 17, 32'h110, 1, 18, 32'h120);
    drive(1, 1, 1, 19, 32'h130, 1, 20, 32'h140);
    idle(4);
    repeat (3000)
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 9) != 0,
            1'($urandom_range(0, 1)), raddr(), $urandom,
            1'($urandom_range(0, 1)), raddr(), $urandom);
    idle(6);
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL provide: clk  input  1  sole clock, all state on posedge.
REQ-002 SHALL provide: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL provide: rdy  input  1  global ready; 0 freezes all state.
REQ-004 SHALL provide: a_valid  input  1  source A (ALU writeback) request.
REQ-005 SHALL provide: a_addr  input  5  A destination register.
REQ-006 SHALL provide: a_data  input  32  A write data.
REQ-007 SHALL provide: a_ready  output  1  A accept; equals rdy AND A buffer empty.
REQ-008 SHALL provide: b_valid, b_addr[4:0], b_data[31:0] inputs and b_ready output, same meaning for source B (load writeback).
REQ-009 SHALL provide: we  output  1  register-file write enable, registered.
REQ-010 SHALL provide: waddr  output  5  register-file write address, registered.
REQ-011 SHALL provide: wdata  output  32  register-file write data, registered.
REQ-012 SHALL provide: pend  output  32  bit i = a buffered, not-yet-issued write to register i exists.

Function
REQ-013 Each source SHALL own a one-entry buffer (valid, addr, data); a_ready/b_ready SHALL depend only on rdy and own buffer valid, never on the other source.
REQ-014 Transfer SHALL occur at a posedge with rst=0, rdy=1, x_valid=1, x_ready=1; the entry SHALL be valid from the next cycle.
REQ-015 A transfer with addr=0 SHALL be accepted and discarded: no buffer fill, no we, no pend bit.
REQ-016 Each cycle with rdy=1 the arbiter SHALL grant exactly one valid buffer if any: that entry loads we=1/waddr/wdata at the edge and its buffer empties at the same edge.
REQ-017 No valid buffer with rdy=1: we SHALL load 0; waddr/wdata SHALL hold.
REQ-018 Both buffers valid, different addr: round-robin; grant the source not granted last; last-grant pointer updates only on a grant.
REQ-019 Both buffers valid, same addr: grant the older entry regardless of pointer; pointer still updates.
REQ-020 Age: an age flag SHALL record which buffer filled first; entries captured at the same edge SHALL treat B as older.
REQ-021 A buffer freed by grant at edge N SHALL show x_ready=1 in cycle N+1; accept-to-we latency min 2 cycles (accept edge N, we high after edge N+1).
REQ-022 No bypass: an incoming request SHALL never reach we in the cycle it is accepted, nor while another buffer is older for the same addr.
REQ-023 pend SHALL be the OR of one-hot(addr) over valid buffers, combinational from buffer state; bit 0 SHALL always be 0; the entry driving we is not pending.
REQ-024 rdy=0: no transfer, no grant, all registers incl. we/waddr/wdata/pointer/age SHALL hold.
REQ-025 Maximum sustained throughput SHALL be one write per cycle; each source SHALL sustain one write per 2 cycles when both are streaming.

Reset
REQ-026 At a posedge with rst=1: both buffers invalid, we=0, waddr=0, wdata=0, pointer=B (A wins first tie), age cleared; pend=0 and a_ready=b_ready=rdy in the following cycle.
REQ-027 rst SHALL take priority over rdy and all requests; buffered and in-flight writes SHALL be discarded without a we pulse.

Verification
REQ-028 A single: a_valid, a_addr=5, a_data=0x11 at edge 0 -> pend[5]=1 cycle 1; we=1, waddr=5, wdata=0x11 cycle 2; pend=0.
REQ-029 Tie: A(3,0xA) and B(4,0xB) accepted same edge, after reset -> order B? no: distinct addr, pointer=B so A issues first, then B on next cycle; we high 2 consecutive cycles.
REQ-030 Same addr: A(7,0x1) and B(7,0x2) same edge -> B (older) issues first, A second; final regfile x7=0x1.
REQ-031 x0 filter: b_addr=0, b_data=0xFFFF_FFFF -> b_ready stays 1, we never asserted, pend=0.
REQ-032 rdy stall: rdy=0 for 3 cycles with both buffers full -> we/waddr/wdata, pend, readys frozen (readys 0); resume issues in round-robin order.
REQ-033 Reset mid-operation: both buffers full, we=1, assert rst one edge -> next cycle we=0, pend=0, a_ready=b_ready=1; discarded data never written.
